// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: drains the ps2_keyboard FIFO and turns raw scan-code bytes into key events.
// Folds E0 (extended) and F0 (break) prefixes into a single event, flags typematic repeats,
// counts distinct presses and keeps a sticky FIFO overflow flag.
//
// Ports:
//   clk, clrn            system clock, synchronous active-low reset
//   kbd_data/ready       FIFO head byte and non-empty flag
//   kbd_overflow         FIFO overflow indication
//   kbd_nextdata_n       active-low FIFO pop (registered, low for one cycle per byte)
//   evt_valid/ready      event handshake; evt_code/ext/break/repeat hold while stalled
//   key_down, held_code  currently held key
//   press_cnt            count of non-repeat presses (wraps)
//   err_clr, err_overflow sticky overflow flag and its clear
module ps2_kbd_ctrl (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] kbd_data,
   input  logic       kbd_ready,
   input  logic       kbd_overflow,
   output logic       kbd_nextdata_n,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_break,
   output logic       evt_repeat,
   output logic       key_down,
   output logic [7:0] held_code,
   output logic [7:0] press_cnt,
   input  logic       err_clr,
   output logic       err_overflow
);

   typedef enum logic [1:0] {StIdle, StAck, StDecode, StEmit} state_e;

   state_e     state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic       nextdata_n_q, nextdata_n_d;
   logic       evt_valid_q, evt_valid_d;
   logic [7:0] evt_code_q, evt_code_d;
   logic       evt_ext_q, evt_ext_d;
   logic       evt_break_q, evt_break_d;
   logic       evt_repeat_q, evt_repeat_d;
   logic       key_down_q, key_down_d;
   logic [7:0] held_code_q, held_code_d;
   logic       held_ext_q, held_ext_d;
   logic [7:0] press_cnt_q, press_cnt_d;
   logic       err_q, err_d;

   always_comb begin
      state_d      = state_q;
      byte_d       = byte_q;
      brk_d        = brk_q;
      ext_d        = ext_q;
      evt_code_d   = evt_code_q;
      evt_ext_d    = evt_ext_q;
      evt_break_d  = evt_break_q;
      evt_repeat_d = evt_repeat_q;
      key_down_d   = key_down_q;
      held_code_d  = held_code_q;
      held_ext_d   = held_ext_q;
      press_cnt_d  = press_cnt_q;

      case (state_q)
         StIdle: begin
            if (kbd_ready) begin
               byte_d  = kbd_data;
               state_d = StAck;
            end
         end
         StAck: state_d = StDecode;
         StDecode: begin
            state_d = StIdle;
            case (byte_q)
               8'hF0: brk_d = 1'b1;
               8'hE0: ext_d = 1'b1;
               8'h00, 8'hFF: begin
                  // Keyboard error codes: drop and forget any pending prefix.
                  brk_d = 1'b0;
                  ext_d = 1'b0;
               end
               default: begin
                  evt_code_d   = byte_q;
                  evt_ext_d    = ext_q;
                  evt_break_d  = brk_q;
                  evt_repeat_d = !brk_q && key_down_q && (held_code_q == byte_q)
                                 && (held_ext_q == ext_q);
                  state_d      = StEmit;
               end
            endcase
         end
         StEmit: begin
            if (evt_ready) begin
               brk_d   = 1'b0;
               ext_d   = 1'b0;
               state_d = StIdle;
               if (!evt_break_q) begin
                  if (!evt_repeat_q) begin
                     held_code_d = evt_code_q;
                     held_ext_d  = evt_ext_q;
                     key_down_d  = 1'b1;
                     press_cnt_d = press_cnt_q + 8'd1;
                  end
               end else if ((held_code_q == evt_code_q) && (held_ext_q == evt_ext_q)) begin
                  key_down_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered off the next state so they line up with the state itself.
      nextdata_n_d = (state_d != StAck);
      evt_valid_d  = (state_d == StEmit);

      // Set dominates clear.
      if (kbd_overflow) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q      <= StIdle;
         byte_q       <= 8'h00;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         nextdata_n_q <= 1'b1;
         evt_valid_q  <= 1'b0;
         evt_code_q   <= 8'h00;
         evt_ext_q    <= 1'b0;
         evt_break_q  <= 1'b0;
         evt_repeat_q <= 1'b0;
         key_down_q   <= 1'b0;
         held_code_q  <= 8'h00;
         held_ext_q   <= 1'b0;
         press_cnt_q  <= 8'h00;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_q       <= byte_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         nextdata_n_q <= nextdata_n_d;
         evt_valid_q  <= evt_valid_d;
         evt_code_q   <= evt_code_d;
         evt_ext_q    <= evt_ext_d;
         evt_break_q  <= evt_break_d;
         evt_repeat_q <= evt_repeat_d;
         key_down_q   <= key_down_d;
         held_code_q  <= held_code_d;
         held_ext_q   <= held_ext_d;
         press_cnt_q  <= press_cnt_d;
         err_q        <= err_d;
      end
   end

   assign kbd_nextdata_n = nextdata_n_q;
   assign evt_valid      = evt_valid_q;
   assign evt_code       = evt_code_q;
   assign evt_ext        = evt_ext_q;
   assign evt_break      = evt_break_q;
   assign evt_repeat     = evt_repeat_q;
   assign key_down       = key_down_q;
   assign held_code      = held_code_q;
   assign press_cnt      = press_cnt_q;
   assign err_overflow   = err_q;

endmodule
